// File: rtl/mp_add_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mp_add_seq_if : issue-side bundle for the multi-precision adder     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface mp_add_seq_if #(
    parameter int MAX_WORDS = 4,
    parameter int NW_W      = 3
);
    logic                      start;
    logic                      op_sub;
    logic [NW_W-1:0]           nwords;
    logic [16*MAX_WORDS-1:0]   a;
    logic [16*MAX_WORDS-1:0]   b;
    logic                      busy;
    logic                      done;
    logic [16*MAX_WORDS-1:0]   result;
    logic                      sign;
    logic                      zero;
    logic                      carry;
    logic                      parity;
    logic                      overflow;

    modport master (
        output start, op_sub, nwords, a, b,
        input  busy, done, result, sign, zero, carry, parity, overflow
    );

    modport slave (
        input  start, op_sub, nwords, a, b,
        output busy, done, result, sign, zero, carry, parity, overflow
    );
endinterface
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mp_add_seq : word-serial multi-precision add/sub with ALU flags     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mp_add_seq #(
    parameter int MAX_WORDS = 4,
    parameter int NW_W      = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    mp_add_seq_if.slave   bus
);
    localparam int c_IDX_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int c_DW    = 16 * MAX_WORDS;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_DW-1:0]     r_a;
    logic [c_DW-1:0]     r_b;
    logic [c_DW-1:0]     r_result;
    logic                r_sub;
    logic                r_cy;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_IDX_W-1:0]  r_lastidx;
    logic                r_sign;
    logic                r_zero;
    logic                r_carry;
    logic                r_parity;
    logic                r_ovf;

    logic [c_IDX_W-1:0]  w_last;
    logic [15:0]         w_aw;
    logic [15:0]         w_bw;
    logic [16:0]         w_sum;
    logic [c_DW-1:0]     w_res_run;
    logic                w_is_last;

    // Index of the final word after clamping nwords into 1..MAX_WORDS
    always_comb begin
        w_last = c_IDX_W'(MAX_WORDS - 1);
        if (bus.nwords == '0)
            w_last = '0;
        else if (bus.nwords <= NW_W'(MAX_WORDS))
            w_last = c_IDX_W'(bus.nwords - 1'b1);
    end

    always_comb begin
        w_aw = '0;
        w_bw = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_aw = r_a[16*i +: 16];
                w_bw = r_b[16*i +: 16];
            end
        end
        if (r_sub)
            w_bw = ~w_bw;
    end

    assign w_sum     = {1'b0, w_aw} + {1'b0, w_bw} + {16'd0, r_cy};
    assign w_is_last = (r_idx == r_lastidx);

    // Result as it will look after this word lands; higher words are still zero
    always_comb begin
        w_res_run = r_result;
        for (int i = 0; i < MAX_WORDS; i++) begin
            if (r_idx == c_IDX_W'(i))
                w_res_run[16*i +: 16] = w_sum[15:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_state_nxt = c_RUN;
            c_RUN:   if (w_is_last) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_sub     <= 1'b0;
            r_cy      <= 1'b0;
            r_idx     <= '0;
            r_lastidx <= '0;
            r_sign    <= 1'b0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_parity  <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (bus.start) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_sub     <= bus.op_sub;
                        r_cy      <= bus.op_sub;
                        r_lastidx <= w_last;
                        r_idx     <= '0;
                        r_result  <= '0;
                    end
                end
                c_RUN: begin
                    r_result <= w_res_run;
                    r_cy     <= w_sum[16];
                    if (!w_is_last) begin
                        r_idx <= r_idx + 1'b1;
                    end else begin
                        // Flags land with the last word so they are valid while done is high
                        r_sign   <= w_sum[15];
                        r_zero   <= ~|w_res_run;
                        r_carry  <= w_sum[16] ^ r_sub;
                        r_parity <= ~^w_res_run;
                        r_ovf    <= (w_aw[15] & w_bw[15] & ~w_sum[15]) |
                                    (~w_aw[15] & ~w_bw[15] & w_sum[15]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (r_state != c_IDLE);
    assign bus.done     = (r_state == c_DONE);
    assign bus.result   = r_result;
    assign bus.sign     = r_sign;
    assign bus.zero     = r_zero;
    assign bus.carry    = r_carry;
    assign bus.parity   = r_parity;
    assign bus.overflow = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mp_add_seq : vector table, random ops vs. arithmetic model       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mp_add_seq;
    localparam int MAX_WORDS = 4;
    localparam int NW_W      = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mp_add_seq_if #(.MAX_WORDS(MAX_WORDS), .NW_W(NW_W)) bus ();

    mp_add_seq #(.MAX_WORDS(MAX_WORDS), .NW_W(NW_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [2:0]  nw;
        logic [63:0] r;
        logic [4:0]  f;   // {sign, zero, carry, parity, overflow}
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow};
    endfunction

    function automatic int neff(input logic [2:0] nw);
        if (nw == 0) return 1;
        if (int'(nw) > MAX_WORDS) return MAX_WORDS;
        return int'(nw);
    endfunction

    // Reference: whole-operand arithmetic on the n-word slice
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic sub,
                         input logic [2:0] nw, output logic [63:0] r, output logic [4:0] f);
        int n;
        logic [79:0] mask, av, bv, s, rr;
        logic sa, sb, sr, cy, ov;
        n    = neff(nw);
        mask = (80'd1 << (16 * n)) - 80'd1;
        av   = {16'd0, a} & mask;
        bv   = {16'd0, b} & mask;
        s    = sub ? (av - bv) : (av + bv);
        rr   = s & mask;
        cy   = sub ? (av < bv) : s[16*n];
        sa   = av[16*n-1];
        sb   = bv[16*n-1];
        sr   = rr[16*n-1];
        ov   = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
        r    = rr[63:0];
        f    = {sr, (rr == 80'd0), cy, ($countones(rr) % 2 == 0), ov};
    endtask

    task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic [2:0] nw,
                          input logic [63:0] er, input logic [4:0] ef);
        int  cyc;
        bit  seen;
        int  n;
        n = neff(nw);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.a      = a;
        bus.b      = b;
        bus.op_sub = sub;
        bus.nwords = nw;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = {$urandom, $urandom};
        bus.b     = {$urandom, $urandom};
        cyc  = 0;
        seen = 0;
        while (cyc < 20 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk({nm, ".busy"}, 80'(bus.busy), 80'd1);
            if (bus.done) seen = 1;
        end
        chk({nm, ".latency"}, 80'(cyc), 80'(n + 1));
        chk({nm, ".result"}, 80'(bus.result), 80'(er));
        chk({nm, ".flags"}, 80'(flags()), 80'(ef));
        @(negedge clk);
        chk({nm, ".done_pulse"}, 80'({bus.done, bus.busy}), 80'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [63:0] ra, rb, er;
        logic [4:0]  ef;
        logic        rs;
        logic [2:0]  rn;
        int d1, d2, ndone, nbusy_after;

        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op_sub = 1'b0;
        bus.nwords = '0;
        bus.a      = '0;
        bus.b      = '0;

        vecs[0] = '{"add1_wrap",  64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 3'd1, 64'h0, 5'b01110};
        vecs[1] = '{"add2_carry", 64'hABCD_1234_0000_FFFF, 64'h5555_0000_0000_0001, 1'b0, 3'd2,
                    64'h0000_0000_0001_0000, 5'b00000};
        vecs[2] = '{"sub4_eq",    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 3'd4,
                    64'h0, 5'b01010};
        vecs[3] = '{"sub4_borrow", 64'h0, 64'h1, 1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 5'b10110};
        vecs[4] = '{"add1_ovf",   64'h7FFF, 64'h0001, 1'b0, 3'd1, 64'h8000, 5'b10001};
        vecs[5] = '{"sub1_ovf",   64'h8000, 64'h0001, 1'b1, 3'd1, 64'h7FFF, 5'b00001};
        vecs[6] = '{"nw0_as1",    64'h0001_0001_0001_FFFF, 64'h1, 1'b0, 3'd0, 64'h0, 5'b01110};
        vecs[7] = '{"nw7_as4",    64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 3'd7, 64'h0, 5'b01110};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.busy_done", 80'({bus.busy, bus.done}), 80'd0);
        chk("reset.result", 80'(bus.result), 80'd0);
        chk("reset.flags", 80'(flags()), 80'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].nw, vecs[i].r, vecs[i].f);

        for (int i = 0; i < 60; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: rb = ra;
                1: rb = ~ra;
                2: ra = 64'h0;
                default: ;
            endcase
            rs = 1'($urandom_range(0, 1));
            rn = 3'($urandom_range(0, 7));
            model(ra, rb, rs, rn, er, ef);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, rn, er, ef);
        end

        // start pulses during RUN and DONE must not launch a second op
        @(negedge clk);
        bus.start = 1'b1; bus.op_sub = 1'b0; bus.nwords = 3'd4;
        bus.a = 64'h0000_0000_0000_0005; bus.b = 64'h0000_0000_0000_0003;
        @(posedge clk);
        #1 bus.start = 1'b0;
        ndone = 0; d1 = 0; nbusy_after = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c >= 7 && bus.busy) nbusy_after++;
            if (bus.done) begin
                ndone++;
                d1 = c;
                chk("ign.result", 80'(bus.result), 80'h8);
                bus.start = 1'b1;
            end else begin
                bus.start = (c == 2);
            end
        end
        bus.start = 1'b0;
        chk("ign.done_count", 80'(ndone), 80'd1);
        chk("ign.done_cycle", 80'(d1), 80'd5);
        chk("ign.no_restart", 80'(nbusy_after), 80'd0);

        // start held high is re-accepted on the first IDLE cycle after done
        @(negedge clk);
        bus.start = 1'b1; bus.op_sub = 1'b0; bus.nwords = 3'd1;
        bus.a = 64'h1; bus.b = 64'h2;
        d1 = 0; d2 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.done) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
            end
        end
        bus.start = 1'b0;
        chk("held.first_done", 80'(d1), 80'd2);
        chk("held.second_done", 80'(d2), 80'd5);
        repeat (6) @(negedge clk);

        // reset in the middle of an n=4 run aborts without a done
        run_op("pre_abort", 64'hFFFF, 64'h1, 1'b0, 3'd1, 64'h0, 5'b01110);
        @(negedge clk);
        bus.start = 1'b1; bus.op_sub = 1'b1; bus.nwords = 3'd4;
        bus.a = 64'h0; bus.b = 64'h1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort.busy_done", 80'({bus.busy, bus.done}), 80'd0);
        chk("abort.result", 80'(bus.result), 80'd0);
        chk("abort.flags", 80'(flags()), 80'd0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        chk("abort.no_done", 80'(ndone), 80'd0);
        run_op("post_abort", 64'h0, 64'h1, 1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 5'b10110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
